baby_cdb_fifo: RTL and testbench

Per-execution-unit result buffer directly upstream of the BIG CDB queue. One instance sits behind each of the five execution units. It captures completed `cdb_t` results in a circular FIFO, presents its oldest live entry to the BIG CDB queue as an enqueue request, and pops that entry when the BIG queue returns `dequeue_bb`. Every held entry tracks branch resolution: masks are cleared on a correct resolve, and entries are killed on a mispredict.

---
 rtl/baby_cdb_fifo_pkg.sv | 18 +
 rtl/baby_cdb_fifo_ebr.sv | 36 +++
 rtl/baby_cdb_fifo.sv | 119 +++++++++++
 tb/tb_baby_cdb_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/baby_cdb_fifo_pkg.sv
// rtl/baby_cdb_fifo_pkg.sv - shared CDB result type and branch-mask width
// Purpose: common types used by the per-unit result FIFO and its helpers.
//   EBR_MASK_SIZE : number of in-flight branches tracked per result
//   cdb_t         : common data bus result (valid, branch mask, tag, value)
package baby_cdb_fifo_pkg;

    localparam int EBR_MASK_SIZE = 4;
    localparam int TAG_W         = 6;
    localparam int XLEN          = 32;

    typedef struct packed {
        logic                     valid;
        logic [EBR_MASK_SIZE-1:0] ebr_mask;
        logic [TAG_W-1:0]         tag;
        logic [XLEN-1:0]          value;
    } cdb_t;

endpackage

// File: rtl/baby_cdb_fifo_ebr.sv
// rtl/baby_cdb_fifo_ebr.sv - branch resolution of one result's valid bit and mask
// Purpose: applies a resolving branch to a single entry.
//   i_valid / i_mask          : entry state before resolution
//   i_bra_done                : a branch resolves this cycle
//   i_bra_mispredict          : the resolving branch mispredicted
//   i_bra_id                  : one-hot id of the resolving branch
//   o_valid / o_mask          : entry state after resolution (pass-through when idle)
module ebr_resolve
    import baby_cdb_fifo_pkg::*;
(
    input  logic                     i_valid,
    input  logic [EBR_MASK_SIZE-1:0] i_mask,
    input  logic                     i_bra_done,
    input  logic                     i_bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] i_bra_id,
    output logic                     o_valid,
    output logic [EBR_MASK_SIZE-1:0] o_mask
);

    logic w_hit;

    assign w_hit = |(i_mask & i_bra_id);

    always_comb begin
        o_valid = i_valid;
        o_mask  = i_mask;
        if (i_bra_done) begin
            // The branch is no longer speculative either way, so its bit goes.
            o_mask = i_mask & ~i_bra_id;
            if (i_bra_mispredict && w_hit) begin
                o_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/baby_cdb_fifo.sv
// rtl/baby_cdb_fifo.sv - per-execution-unit result FIFO feeding the BIG CDB queue
// Purpose: buffers completed results, presents the oldest live one, and tracks
// branch resolution on every held entry (killed entries become holes).
//   clk, rst (async, active-low)
//   push, push_data          : result from the execution unit
//   full                     : registered; unit must not push while high
//   enqueue, rdata           : head entry offered to the BIG queue
//   dequeue_bb               : BIG queue accepted the head
//   bra_done, bra_mispredict, bra_id : branch resolution broadcast
module baby_cdb_fifo
    import baby_cdb_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cdb_t                     push_data,
    output logic                     full,
    output logic                     enqueue,
    output cdb_t                     rdata,
    input  logic                     dequeue_bb,
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] bra_id
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    cdb_t                     r_mem [DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic                     r_full;

    logic                     w_empty;
    cdb_t                     w_head_entry;
    logic                     w_pop;
    logic                     w_push_ok;
    logic                     w_push_res_valid;
    logic [EBR_MASK_SIZE-1:0] w_push_res_mask;
    cdb_t                     w_push_entry;
    logic [PTR_W-1:0]         w_head_nxt;
    logic [PTR_W-1:0]         w_tail_nxt;
    logic                     w_res_valid [DEPTH];
    logic [EBR_MASK_SIZE-1:0] w_res_mask  [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_ebr
        ebr_resolve u_ebr (
            .i_valid          (r_mem[g].valid),
            .i_mask           (r_mem[g].ebr_mask),
            .i_bra_done       (bra_done),
            .i_bra_mispredict (bra_mispredict),
            .i_bra_id         (bra_id),
            .o_valid          (w_res_valid[g]),
            .o_mask           (w_res_mask[g])
        );
    end

    // The incoming result is resolved too, so a result born under a branch
    // that dies this cycle never enters the FIFO.
    ebr_resolve u_ebr_push (
        .i_valid          (1'b1),
        .i_mask           (push_data.ebr_mask),
        .i_bra_done       (bra_done),
        .i_bra_mispredict (bra_mispredict),
        .i_bra_id         (bra_id),
        .o_valid          (w_push_res_valid),
        .o_mask           (w_push_res_mask)
    );

    assign w_empty      = (r_head == r_tail);
    assign w_head_entry = r_mem[r_head[IDX_W-1:0]];

    // Registered state only; the BIG queue applies its own same-cycle kill.
    assign enqueue = !w_empty && w_head_entry.valid;
    assign rdata   = w_head_entry;
    assign full    = r_full;

    // A hole at the head drains on its own, one per cycle.
    assign w_pop     = !w_empty && (!w_head_entry.valid || dequeue_bb);
    assign w_push_ok = push && !r_full && w_push_res_valid;

    assign w_head_nxt = r_head + PTR_W'(w_pop);
    assign w_tail_nxt = r_tail + PTR_W'(w_push_ok);

    always_comb begin
        w_push_entry          = push_data;
        w_push_entry.valid    = 1'b1;
        w_push_entry.ebr_mask = w_push_res_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_full <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            r_full <= (w_head_nxt[IDX_W-1:0] == w_tail_nxt[IDX_W-1:0]) &&
                      (w_head_nxt[IDX_W] != w_tail_nxt[IDX_W]);
            for (int i = 0; i < DEPTH; i++) begin
                // The tail slot is never live while not full, so a write
                // there cannot collide with resolution of a held entry.
                if (w_push_ok && (r_tail[IDX_W-1:0] == IDX_W'(i))) begin
                    r_mem[i] <= w_push_entry;
                end else begin
                    r_mem[i].valid    <= w_res_valid[i];
                    r_mem[i].ebr_mask <= w_res_mask[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_baby_cdb_fifo.sv
// tb/tb_baby_cdb_fifo.sv - scoreboard bench for baby_cdb_fifo
module tb_baby_cdb_fifo;
    import baby_cdb_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int M     = EBR_MASK_SIZE;

    logic         clk;
    logic         rst;
    logic         push;
    cdb_t         push_data;
    logic         full;
    logic         enqueue;
    cdb_t         rdata;
    logic         dequeue_bb;
    logic         bra_done;
    logic         bra_mispredict;
    logic [M-1:0] bra_id;

    baby_cdb_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .push_data      (push_data),
        .full           (full),
        .enqueue        (enqueue),
        .rdata          (rdata),
        .dequeue_bb     (dequeue_bb),
        .bra_done       (bra_done),
        .bra_mispredict (bra_mispredict),
        .bra_id         (bra_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the FIFO contents in age order, holes included.
    cdb_t model_q[$];
    cdb_t sb_q[$];
    int   n_cmp;
    int   n_bad;
    int   n_tail_moves;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cdb_t mk(input logic [M-1:0] mask, input logic [31:0] val);
        cdb_t d;
        d.valid    = 1'($urandom);
        d.ebr_mask = mask;
        d.tag      = TAG_W'($urandom);
        d.value    = val;
        return d;
    endfunction

    // Monitor: every accepted handshake must match the oldest expected delivery.
    initial begin
        cdb_t e;
        forever begin
            @(negedge clk);
            if (rst && enqueue && dequeue_bb) begin
                check("sb_has_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_rdata", 64'(rdata), 64'(e));
                end
            end
        end
    end

    // Called at posedge+1: drive one cycle, check outputs, advance the model.
    task automatic step(input bit p, input cdb_t d, input bit deq,
                        input bit done, input bit mis, input logic [M-1:0] id);
        bit   exp_full, exp_enq, pop, drop;
        cdb_t ne;
        push = p; push_data = d; dequeue_bb = deq;
        bra_done = done; bra_mispredict = mis; bra_id = id;
        exp_full = (model_q.size() == DEPTH);
        exp_enq  = (model_q.size() > 0) && model_q[0].valid;
        check("full", 64'(full), 64'(exp_full));
        check("enqueue", 64'(enqueue), 64'(exp_enq));
        if (exp_enq) check("rdata_head", 64'(rdata), 64'(model_q[0]));
        if (exp_enq && deq) sb_q.push_back(model_q[0]);

        pop = (model_q.size() > 0) && (!model_q[0].valid || deq);
        ne = d;
        ne.valid = 1'b1;
        drop = 1'b0;
        if (done) begin
            foreach (model_q[k]) begin
                if (mis && ((model_q[k].ebr_mask & id) != 0)) model_q[k].valid = 1'b0;
                model_q[k].ebr_mask = model_q[k].ebr_mask & ~id;
            end
            if (mis && ((ne.ebr_mask & id) != 0)) drop = 1'b1;
            ne.ebr_mask = ne.ebr_mask & ~id;
        end
        if (pop) void'(model_q.pop_front());
        if (p && !exp_full && !drop) begin
            model_q.push_back(ne);
            n_tail_moves++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit deq, input int n);
        for (int i = 0; i < n; i++) step(0, '0, deq, 0, 0, '0);
    endtask

    task automatic check_tail();
        check("tail_ptr", 64'(dut.r_tail), 64'(n_tail_moves % (2 * DEPTH)));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_tail_moves = 0;
        rst = 1'b0; push = 0; push_data = '0; dequeue_bb = 0;
        bra_done = 0; bra_mispredict = 0; bra_id = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_enqueue", 64'(enqueue), 64'd0);
        check("reset_full", 64'(full), 64'd0);
        check("reset_rdata_valid", 64'(rdata.valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic order with dequeue held high.
        step(1, mk(4'b0000, 32'hA), 1, 0, 0, '0);
        step(1, mk(4'b0000, 32'hB), 1, 0, 0, '0);
        step(1, mk(4'b0000, 32'hC), 1, 0, 0, '0);
        idle(1, 3);

        // Fill, ignored push while full, then pop 2 / push 2 across the wrap.
        for (int i = 0; i < DEPTH; i++) step(1, mk(4'b0000, 32'h10 + i), 0, 0, 0, '0);
        step(1, mk(4'b0000, 32'h99), 0, 0, 0, '0);
        check_tail();
        idle(1, 2);
        step(1, mk(4'b0000, 32'h20), 0, 0, 0, '0);
        step(1, mk(4'b0000, 32'h21), 0, 0, 0, '0);
        check_tail();
        idle(1, DEPTH + 2);

        // Mispredict kill, then correct resolve, on masks 01,10,01.
        for (int r = 0; r < 2; r++) begin
            step(1, mk(4'b0001, 32'h30), 0, 0, 0, '0);
            step(1, mk(4'b0010, 32'h31), 0, 0, 0, '0);
            step(1, mk(4'b0001, 32'h32), 0, 0, 0, '0);
            step(0, '0, 0, 1, (r == 0), 4'b0001);
            idle(1, 5);
        end

        // Push killed by a same-cycle mispredict.
        step(1, mk(4'b0100, 32'h40), 0, 1, 1, 4'b0100);
        check_tail();
        idle(1, 2);

        // Asynchronous reset between edges with a full FIFO.
        for (int i = 0; i < DEPTH; i++) step(1, mk(4'b0000, 32'h50 + i), 0, 0, 0, '0);
        check("pre_reset_full", 64'(full), 64'd1);
        push = 0; dequeue_bb = 0; bra_done = 0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_enqueue", 64'(enqueue), 64'd0);
        check("async_reset_full", 64'(full), 64'd0);
        model_q.delete();
        sb_q.delete();
        n_tail_moves = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, mk(4'b0000, 32'h60), 0, 0, 0, '0);
        check("post_reset_enqueue", 64'(enqueue), 64'd1);
        idle(1, 2);

        // Randomized traffic with branch activity.
        for (int i = 0; i < 3000; i++) begin
            logic [M-1:0] rid;
            rid = M'(1) << $urandom_range(0, M - 1);
            step(($urandom_range(0, 3) != 0), mk(M'($urandom), $urandom),
                 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), rid);
        end
        idle(1, 2 * DEPTH + 2);
        check("final_model_empty", 64'(model_q.size()), 64'd0);
        check("final_sb_drained", 64'(sb_q.size()), 64'd0);
        check("final_enqueue", 64'(enqueue), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
